// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, ALU ops,
// FSM states, trap causes, instruction classes and datapath mux selects.
package package_param;

  localparam logic [6:0] RTYPE    = 7'b0110011;
  localparam logic [6:0] ITYPE    = 7'b0010011;
  localparam logic [6:0] ILTYPE   = 7'b0000011;
  localparam logic [6:0] STYPE    = 7'b0100011;
  localparam logic [6:0] BTYPE    = 7'b1100011;
  localparam logic [6:0] JALTYPE  = 7'b1101111;
  localparam logic [6:0] JALRTYPE = 7'b1100111;
  localparam logic [6:0] U1TYPE   = 7'b0110111;  // LUI
  localparam logic [6:0] U2TYPE   = 7'b0010111;  // AUIPC

  // ALU ops are {funct7[5], funct3}, so R/I-type words map straight through
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_MUL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [1:0] OP1_RS1  = 2'b00;
  localparam logic [1:0] OP1_PC   = 2'b01;
  localparam logic [1:0] OP1_ZERO = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_LOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } cu_state_t;

  typedef enum logic [1:0] {
    TC_NONE    = 2'b00,
    TC_ILLEGAL = 2'b01,
    TC_TIMEOUT = 2'b10
  } trap_cause_t;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_MUL
  } instr_class_t;

endpackage

// File: rtl/multicycle_control_unit_cu_decoder.sv
// Combinational instruction decoder for the control unit.
// RV32M_EN additionally accepts R-type MUL (funct7 0000001, funct3 000).
module cu_decoder
  import package_param::*;
(
  input  logic [31:0]   instr,
  output logic [3:0]    alu_opcode,
  output logic          br_unsign,
  output logic [1:0]    op1_sel,
  output logic          op2_sel,
  output logic [1:0]    wb_sel,
  output instr_class_t  instr_class,
  output logic          illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    alu_opcode  = ALU_ADD;
    br_unsign   = 1'b0;
    op1_sel     = OP1_RS1;
    op2_sel     = 1'b1;
    wb_sel      = WB_ALU;
    instr_class = CL_I;
    illegal     = 1'b0;
    case (opcode)
      RTYPE: begin
        instr_class = CL_R;
        op2_sel     = 1'b0;
        alu_opcode  = {funct7[5], funct3};
        if (funct7 == 7'b0000001) begin
`ifdef RV32M_EN
          if (funct3 == 3'b000) begin
            instr_class = CL_MUL;
            alu_opcode  = ALU_MUL;
          end else begin
            illegal = 1'b1;
          end
`else
          illegal = 1'b1;
`endif
        end else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
          illegal = 1'b1;
        end
      end
      // only shift-right-immediate carries the arithmetic bit in instr[30]
      ITYPE:    alu_opcode = (funct3 == 3'b101) ? {instr[30], funct3} : {1'b0, funct3};
      ILTYPE: begin
        instr_class = CL_LOAD;
        wb_sel      = WB_LOAD;
      end
      STYPE:    instr_class = CL_STORE;
      BTYPE: begin
        instr_class = CL_BRANCH;
        op1_sel     = OP1_PC;
        br_unsign   = (funct3[2:1] == 2'b11);
      end
      JALTYPE: begin
        instr_class = CL_JAL;
        op1_sel     = OP1_PC;
        wb_sel      = WB_PC4;
      end
      JALRTYPE: begin
        instr_class = CL_JALR;
        wb_sel      = WB_PC4;
      end
      U1TYPE: begin
        instr_class = CL_LUI;
        op1_sel     = OP1_ZERO;
      end
      U2TYPE: begin
        instr_class = CL_AUIPC;
        op1_sel     = OP1_PC;
      end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Sequencing FSM for the multi-cycle RV32I core: fetch/decode/exec/mem/wb,
// memory handshake with timeout trap, retire counter. RV32M_EN adds MUL.
module multicycle_control_unit
  import package_param::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 8,
  parameter int INSTRET_W   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [31:0]          i_instr,
  input  logic                 i_mem_ready,
  input  logic                 i_br_taken,
  input  logic                 i_mul_done,
  output logic                 o_ir_wren,
  output logic                 o_pc_wren,
  output logic                 o_pc_sel,
  output logic [1:0]           o_op1_sel,
  output logic                 o_op2_sel,
  output logic [3:0]           o_alu_opcode,
  output logic                 o_br_unsign,
  output logic                 o_rd_wren,
  output logic [1:0]           o_wb_sel,
  output logic                 o_mem_req,
  output logic                 o_mem_wren,
  output logic                 o_mul_start,
  output logic                 o_trap,
  output logic [1:0]           o_trap_cause,
  output logic [INSTRET_W-1:0] o_instret
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  cu_state_t            state, state_next;
  trap_cause_t          cause, cause_next;
  logic [TMO_W-1:0]     tmo, tmo_next;
  logic [INSTRET_W-1:0] instret;
  logic                 retire;
  logic                 wait_tick;
  logic                 timed_out;

  logic [3:0]   dec_alu;
  logic         dec_br_unsign;
  logic [1:0]   dec_op1;
  logic         dec_op2;
  logic [1:0]   dec_wb;
  instr_class_t dec_class;
  logic         dec_illegal;

`ifdef RV32M_EN
  logic mul_wait, mul_wait_next;
`else
  logic unused_mul_done;
  assign unused_mul_done = i_mul_done;
  assign o_mul_start     = 1'b0;
`endif

  cu_decoder u_decoder (
    .instr       (i_instr),
    .alu_opcode  (dec_alu),
    .br_unsign   (dec_br_unsign),
    .op1_sel     (dec_op1),
    .op2_sel     (dec_op2),
    .wb_sel      (dec_wb),
    .instr_class (dec_class),
    .illegal     (dec_illegal)
  );

  // a ready arriving in the limit cycle is checked first, so it wins
  assign timed_out = (MEM_TIMEOUT != 0) && (tmo == TMO_LIMIT);

  always_comb begin
    state_next   = state;
    cause_next   = cause;
    retire       = 1'b0;
    wait_tick    = 1'b0;
    o_ir_wren    = 1'b0;
    o_pc_wren    = 1'b0;
    o_pc_sel     = 1'b0;
    o_op1_sel    = OP1_RS1;
    o_op2_sel    = 1'b0;
    o_alu_opcode = ALU_ADD;
    o_br_unsign  = 1'b0;
    o_rd_wren    = 1'b0;
    o_wb_sel     = WB_ALU;
    o_mem_req    = 1'b0;
    o_mem_wren   = 1'b0;
`ifdef RV32M_EN
    o_mul_start   = 1'b0;
    mul_wait_next = 1'b0;
`endif
    // ALU stays steered through MEM and WB so addresses/targets remain valid
    if (state inside {ST_EXEC, ST_MEM, ST_WB}) begin
      o_alu_opcode = dec_alu;
      o_br_unsign  = dec_br_unsign;
      o_op1_sel    = dec_op1;
      o_op2_sel    = dec_op2;
    end
    case (state)
      ST_RST:    state_next = ST_FETCH;
      ST_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_ir_wren  = 1'b1;
          state_next = ST_DECODE;
        end else if (timed_out) begin
          state_next = ST_TRAP;
          cause_next = TC_TIMEOUT;
        end else begin
          wait_tick = 1'b1;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_next = ST_TRAP;
          cause_next = TC_ILLEGAL;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (dec_class)
          CL_BRANCH: begin
            o_pc_wren  = 1'b1;
            o_pc_sel   = i_br_taken;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
          CL_LOAD, CL_STORE: state_next = ST_MEM;
`ifdef RV32M_EN
          CL_MUL: begin
            o_mul_start = !mul_wait;
            if (i_mul_done) state_next = ST_WB;
            else            mul_wait_next = 1'b1;
          end
`endif
          default:   state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        o_mem_req  = 1'b1;
        o_mem_wren = (dec_class == CL_STORE);
        if (i_mem_ready) begin
          if (dec_class == CL_STORE) begin
            o_pc_wren  = 1'b1;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (timed_out) begin
          state_next = ST_TRAP;
          cause_next = TC_TIMEOUT;
        end else begin
          wait_tick = 1'b1;
        end
      end
      ST_WB: begin
        o_rd_wren  = (i_instr[11:7] != 5'd0);
        o_pc_wren  = 1'b1;
        o_pc_sel   = (dec_class == CL_JAL) || (dec_class == CL_JALR);
        o_wb_sel   = dec_wb;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_TRAP:   state_next = ST_TRAP;
      default:   state_next = ST_RST;
    endcase
    if (state_next != state) tmo_next = '0;
    else if (wait_tick)      tmo_next = tmo + TMO_W'(1);
    else                     tmo_next = tmo;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_RST;
      cause   <= TC_NONE;
      tmo     <= '0;
      instret <= '0;
    end else begin
      state <= state_next;
      cause <= cause_next;
      tmo   <= tmo_next;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end

`ifdef RV32M_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mul_wait <= 1'b0;
    else          mul_wait <= mul_wait_next;
  end
`endif

  assign o_trap       = (state == ST_TRAP);
  assign o_trap_cause = cause;
  assign o_instret    = instret;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (MEM_TIMEOUT = 4); honours RV32M_EN.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready, br_taken, mul_done;
  logic        ir_wren, pc_wren, pc_sel, op2_sel, br_unsign, rd_wren;
  logic        mem_req, mem_wren, mul_start, trap;
  logic [1:0]  op1_sel, wb_sel, trap_cause;
  logic [3:0]  alu_opcode;
  logic [31:0] instret;
  logic [19:0] all_outs;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.MEM_TIMEOUT(4), .TMO_W(8), .INSTRET_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_mem_ready(mem_ready),
    .i_br_taken(br_taken), .i_mul_done(mul_done), .o_ir_wren(ir_wren),
    .o_pc_wren(pc_wren), .o_pc_sel(pc_sel), .o_op1_sel(op1_sel),
    .o_op2_sel(op2_sel), .o_alu_opcode(alu_opcode), .o_br_unsign(br_unsign),
    .o_rd_wren(rd_wren), .o_wb_sel(wb_sel), .o_mem_req(mem_req),
    .o_mem_wren(mem_wren), .o_mul_start(mul_start), .o_trap(trap),
    .o_trap_cause(trap_cause), .o_instret(instret)
  );

  assign all_outs = {ir_wren, pc_wren, pc_sel, op1_sel, op2_sel, alu_opcode, br_unsign,
                     rd_wren, wb_sel, mem_req, mem_wren, mul_start, trap, trap_cause};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // drive a word through FETCH (ready at once); returns in DECODE
  task automatic fetch_decode(input logic [31:0] word);
    instr     = word;
    mem_ready = 1'b1;
    #1;
    check_eq("fetch_req", mem_req, 1'b1);
    check_eq("fetch_irw", ir_wren, 1'b1);
    next_cycle();
    mem_ready = 1'b0;
    #1;
    check_eq("decode_req", mem_req, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic run_wb(input string tag, input logic [31:0] word, input logic [3:0] alu,
                        input logic [1:0] op1, input logic op2, input logic rdw,
                        input logic psel, input logic [1:0] wbs, input logic [31:0] ret);
    fetch_decode(word);
    next_cycle(); #1;
    check_eq({tag, "_alu"}, alu_opcode, alu);
    check_eq({tag, "_op1"}, op1_sel, op1);
    check_eq({tag, "_op2"}, op2_sel, op2);
    check_eq({tag, "_exec_rdw"}, rd_wren, 1'b0);
    next_cycle(); #1;
    check_eq({tag, "_wb_rdw"}, rd_wren, rdw);
    check_eq({tag, "_wb_pcw"}, pc_wren, 1'b1);
    check_eq({tag, "_wb_pcsel"}, pc_sel, psel);
    check_eq({tag, "_wb_sel"}, wb_sel, wbs);
    check_eq({tag, "_wb_instret"}, instret, ret - 1);
    next_cycle(); #1;
    check_eq({tag, "_instret"}, instret, ret);
  endtask

  task automatic run_br(input string tag, input logic [31:0] word, input logic taken,
                        input logic unsign, input logic [31:0] ret);
    fetch_decode(word);
    next_cycle();
    br_taken = taken;
    #1;
    check_eq({tag, "_pcsel"}, pc_sel, taken);
    check_eq({tag, "_pcw"}, pc_wren, 1'b1);
    check_eq({tag, "_rdw"}, rd_wren, 1'b0);
    check_eq({tag, "_op1"}, op1_sel, 2'b01);
    check_eq({tag, "_unsign"}, br_unsign, unsign);
    next_cycle();
    br_taken = 1'b0;
    #1;
    check_eq({tag, "_instret"}, instret, ret);
    check_eq({tag, "_back_fetch"}, mem_req, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst_n = 1'b0; instr = 32'h0; mem_ready = 1'b0; br_taken = 1'b0; mul_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_outs", all_outs, 20'h0);
    check_eq("rst_instret", instret, 32'h0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_state_noreq", mem_req, 1'b0);
    next_cycle();

    run_wb("add",  32'h002081B3, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 32'd1);

    // LW x5,0(x1) with 3 wait cycles in MEM
    fetch_decode(32'h0000A283);
    next_cycle(); #1;
    check_eq("lw_exec_op2", op2_sel, 1'b1);
    check_eq("lw_exec_req", mem_req, 1'b0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      check_eq("lw_mem_req", mem_req, 1'b1);
      check_eq("lw_mem_wren", mem_wren, 1'b0);
      next_cycle();
    end
    mem_ready = 1'b0;
    #1;
    check_eq("lw_wb_sel", wb_sel, 2'b11);
    check_eq("lw_wb_rdw", rd_wren, 1'b1);
    next_cycle(); #1;
    check_eq("lw_instret", instret, 32'd2);

    // SW x2,4(x1)
    fetch_decode(32'h0020A223);
    next_cycle(); next_cycle();
    mem_ready = 1'b1;
    #1;
    check_eq("sw_mem_wren", mem_wren, 1'b1);
    check_eq("sw_pcw", pc_wren, 1'b1);
    check_eq("sw_rdw", rd_wren, 1'b0);
    next_cycle();
    mem_ready = 1'b0;
    #1;
    check_eq("sw_instret", instret, 32'd3);

    run_br("beq_nt", 32'h00208463, 1'b0, 1'b0, 32'd4);
    run_br("beq_t",  32'h00208463, 1'b1, 1'b0, 32'd5);
    run_br("bltu",   32'h0020E463, 1'b1, 1'b1, 32'd6);

    run_wb("jal",  32'h010000EF, 4'h0, 2'b01, 1'b1, 1'b1, 1'b1, 2'b10, 32'd7);
    run_wb("lui0", 32'h12345037, 4'h0, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 32'd8);
    run_wb("sub",  32'h402081B3, 4'h8, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 32'd9);
    run_wb("srai", 32'h4030D193, 4'hD, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 32'd10);

    // MUL x3,x1,x2
    fetch_decode(32'h022081B3);
    next_cycle();
`ifdef RV32M_EN
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      mul_done = (i == 5);
      #1;
      pulses += int'(mul_start);
      check_eq("mul_exec_alu", alu_opcode, 4'hA);
      check_eq("mul_exec_rdw", rd_wren, 1'b0);
      check_eq("mul_no_trap", trap, 1'b0);
      next_cycle();
    end
    mul_done = 1'b0;
    #1;
    check_eq("mul_pulses", pulses, 32'd1);
    check_eq("mul_wb_rdw", rd_wren, 1'b1);
    next_cycle(); #1;
    check_eq("mul_instret", instret, 32'd11);
`else
    pulses = 0;
    #1;
    check_eq("mul_trap", trap, 1'b1);
    check_eq("mul_cause", trap_cause, 2'b01);
    check_eq("mul_start_tied", mul_start + pulses, 32'd0);
`endif

    // illegal opcode 0x7F
    do_reset();
    fetch_decode(32'h0000007F);
    next_cycle(); #1;
    check_eq("ill_trap", trap, 1'b1);
    check_eq("ill_cause", trap_cause, 2'b01);
    check_eq("ill_instret", instret, 32'd0);
    for (int i = 0; i < 3; i++) begin
      mem_ready = i[0];
      next_cycle(); #1;
      check_eq("ill_noreq", mem_req, 1'b0);
      check_eq("ill_sticky", trap, 1'b1);
    end
    mem_ready = 1'b0;

    // fetch timeout: 4 waits allowed, trap when the limit is reached
    do_reset();
    instr = 32'h002081B3;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("tmo_wait_req", mem_req, 1'b1);
      check_eq("tmo_wait_trap", trap, 1'b0);
      next_cycle();
    end
    #1;
    check_eq("tmo_trap", trap, 1'b1);
    check_eq("tmo_cause", trap_cause, 2'b10);
    check_eq("tmo_req_drop", mem_req, 1'b0);
    next_cycle(); #1;
    check_eq("tmo_hold_req", mem_req, 1'b0);

    // ready in the limit cycle wins
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 4);
      #1;
      check_eq("race_req", mem_req, 1'b1);
      next_cycle();
    end
    mem_ready = 1'b0;
    #1;
    check_eq("race_no_trap", trap, 1'b0);
    check_eq("race_decode", mem_req, 1'b0);
    next_cycle(); next_cycle(); next_cycle(); #1;
    check_eq("race_instret", instret, 32'd1);

    // asynchronous reset mid-wait
    next_cycle(); next_cycle(); #1;
    check_eq("arst_pre_req", mem_req, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_outs", all_outs, 20'h0);
    check_eq("arst_instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle(); #1;
    check_eq("arst_refetch", mem_req, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
